// File: rtl/zd_sched.sv
// zd_sched -- round-robin scheduler sharing one bit-serial Mealy zero detector
// among N requesters.
//
// The granted requester's W-bit word is latched and shifted to the detector
// LSB-first. The detector is cleared for one cycle before each word. The
// scheduler counts the cycles in which det_y is high and returns that count
// with a one-cycle done pulse.
//
// Optional feature: define ZD_SCHED_STATS_EN to add the total_hits output.
// total_hits is a saturating 16-bit running sum of hit_count over all
// completed jobs.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   req[N]     per-requester job request (level)
//   data[N*W]  requester words, slice i = data[i*W +: W]
//   gnt[N]     one-hot grant, held from CLEAR through REPORT
//   det_x      serial bit to the detector
//   det_rst    registered active-low clear to the detector
//   det_y      detector output (Mealy, combinational on det_x)
//   busy       high in any state except IDLE
//   done       one-cycle pulse in REPORT
//   done_id    index of the finished requester, held until the next done
//   hit_count  det_y=1 count for the finished job, held until the next done
//   total_hits (ZD_SCHED_STATS_EN only) cumulative saturating hit sum
module zd_sched #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int CW = $clog2(W + 1),
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  data,
    output logic [N-1:0]    gnt,
    output logic            det_x,
    output logic            det_rst,
    input  logic            det_y,
    output logic            busy,
    output logic            done,
    output logic [IW-1:0]   done_id,
`ifdef ZD_SCHED_STATS_EN
    output logic [CW-1:0]   hit_count,
    output logic [15:0]     total_hits
`else
    output logic [CW-1:0]   hit_count
`endif
);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   bit_q, bit_d;
    logic [IW-1:0]   done_id_q, done_id_d;
    logic [CW-1:0]   hit_q, hit_d;
    logic            det_rst_q, det_rst_d;
    logic [IW-1:0]   sel;
    logic            found;

    // Round-robin pick: first set request searching upward from last+1.
    always_comb begin
        int j;
        j     = 0;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(last_q) + i) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        done_id_d = done_id_q;
        hit_d     = hit_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    shift_d    = data[int'(sel)*W +: W];
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    last_d     = sel;
                    cnt_d      = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (det_y) cnt_d = cnt_q + CW'(1);
                shift_d = shift_q >> 1;
                bit_d   = bit_q + CW'(1);
                // Capture results on the last shift edge so they are
                // already valid while done is high.
                if (bit_q == CW'(W - 1)) begin
                    state_d   = REPORT;
                    hit_d     = cnt_d;
                    done_id_d = last_q;
                end
            end
            REPORT: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Detector clear is registered: low exactly while in CLEAR.
        det_rst_d = (state_d != CLEAR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            gnt_q     <= '0;
            last_q    <= IW'(N - 1);
            cnt_q     <= '0;
            bit_q     <= '0;
            done_id_q <= '0;
            hit_q     <= '0;
            det_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            done_id_q <= done_id_d;
            hit_q     <= hit_d;
            det_rst_q <= det_rst_d;
        end
    end

    assign gnt       = gnt_q;
    assign det_x     = (state_q == SHIFT) & shift_q[0];
    assign det_rst   = det_rst_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == REPORT);
    assign done_id   = done_id_q;
    assign hit_count = hit_q;

`ifdef ZD_SCHED_STATS_EN
    logic [15:0] total_q, total_d;
    logic [16:0] sum;

    always_comb begin
        sum     = {1'b0, total_q} + {{(17 - CW){1'b0}}, hit_q};
        total_d = total_q;
        if (state_q == REPORT) total_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) total_q <= '0;
        else      total_q <= total_d;
    end

    assign total_hits = total_q;
`endif

endmodule

// File: tb/tb_zd_sched.sv
module tb_zd_sched;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk, rst;
    logic [N-1:0]  req;
    logic [N*W-1:0] data;
    logic [N-1:0]  gnt;
    logic          det_x, det_rst, det_y, busy, done;
    logic [1:0]    done_id;
    logic [CW-1:0] hit_count;
`ifdef ZD_SCHED_STATS_EN
    logic [15:0]   total_hits;
`endif

    int checks = 0;
    int errors = 0;
    int m_last = N - 1;

    zd_sched #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt),
        .det_x(det_x), .det_rst(det_rst), .det_y(det_y), .busy(busy),
        .done(done), .done_id(done_id),
`ifdef ZD_SCHED_STATS_EN
        .hit_count(hit_count), .total_hits(total_hits)
`else
        .hit_count(hit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector model: y=1 when the current bit is 0 and the previous bit
    // since clear was 1.
    logic prev;
    always_ff @(posedge clk or negedge det_rst) begin
        if (!det_rst) prev <= 1'b0;
        else          prev <= det_x;
    end
    assign det_y = ~det_x & prev;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: a hit is every 1->0 transition within the word, LSB-first.
    function automatic int exp_hits(input logic [W-1:0] w);
        int h = 0;
        for (int i = 1; i < W; i++) if (w[i-1] && !w[i]) h++;
        return h;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Continuous structural checks.
    always @(negedge clk) begin
        if (rst) begin
            if (busy) chk("gnt_onehot", int'($onehot(gnt)), 1);
            else      chk("gnt_idle_zero", int'(gnt), 0);
            if (!busy) chk("detx_idle_zero", int'(det_x), 0);
        end
    end

    task automatic do_reset();
        req = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_last = N - 1;
    endtask

    task automatic wait_done(input string nm, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
    endtask

    // Request, drop req once granted, wait for done, compare results.
    task automatic run_job(input string nm, input logic [N-1:0] r,
                           input logic [N*W-1:0] d, input int eid, input int ehit);
        bit ok;
        @(negedge clk);
        req  = r;
        data = d;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (gnt != 0) begin ok = 1'b1; break; end
        end
        req = '0;
        chk({nm, "_gnt"}, int'(gnt), 1 << eid);
        if (ok) begin
            wait_done(nm, ok);
            if (ok) begin
                chk({nm, "_id"}, int'(done_id), eid);
                chk({nm, "_hit"}, int'(hit_count), ehit);
            end
        end
        m_last = eid;
    endtask

    typedef struct {
        logic [N-1:0]   r;
        logic [N*W-1:0] d;
        int             id;
        int             hit;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit ok;
        logic [N-1:0]   rv;
        logic [N*W-1:0] dv;
        int eid, ehit;

        tbl[0] = '{4'b0010, 32'h0000_0000, 1, 0};
        tbl[1] = '{4'b0010, 32'h0000_FF00, 1, 0};
        tbl[2] = '{4'b0010, 32'h0000_0F00, 1, 1};
        tbl[3] = '{4'b0001, 32'h0000_000F, 0, 1};
        tbl[4] = '{4'b1001, 32'hAA00_0055, 3, 3};
        tbl[5] = '{4'b1001, 32'hAA00_0055, 0, 4};
        tbl[6] = '{4'b0110, 32'h003C_3C00, 1, 1};

        req = '0; data = '0; rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_detrst", int'(det_rst), 0);
        chk("rst_detx", int'(det_x), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_id", int'(done_id), 0);
        chk("rst_hit", int'(hit_count), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_detrst", int'(det_rst), 1);

        // Full trace of one 0x55 job.
        req = 4'b0001; data = 32'h0000_0055;
        @(negedge clk);
        chk("t55_gnt", int'(gnt), 1);
        chk("t55_clear_detrst", int'(det_rst), 0);
        chk("t55_clear_detx", int'(det_x), 0);
        req = '0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk($sformatf("t55_detx%0d", i), int'(det_x), (i % 2 == 0) ? 1 : 0);
            chk("t55_shift_detrst", int'(det_rst), 1);
            chk("t55_shift_done", int'(done), 0);
        end
        @(negedge clk);
        chk("t55_done", int'(done), 1);
        chk("t55_id", int'(done_id), 0);
        chk("t55_hit", int'(hit_count), 4);
        @(negedge clk);
        chk("t55_after_done", int'(done), 0);
        chk("t55_after_busy", int'(busy), 0);
        chk("t55_held_hit", int'(hit_count), 4);
        m_last = 0;

        foreach (tbl[i]) run_job($sformatf("tbl%0d", i), tbl[i].r, tbl[i].d, tbl[i].id, tbl[i].hit);

        // All four requesting continuously.
        do_reset();
        @(negedge clk);
        req = 4'b1111; data = 32'h0FAA_FF55;
        for (int k = 0; k < 5; k++) begin
            wait_done("all4", ok);
            if (!ok) break;
            chk($sformatf("all4_id%0d", k), int'(done_id), k % N);
            chk($sformatf("all4_hit%0d", k), int'(hit_count), exp_hits(data[(k % N)*W +: W]));
            if (k == 4) req = '0;
            @(negedge clk);
            chk("all4_idle_gap", int'(busy), 0);
        end
        req = '0;

        // Reset in the middle of SHIFT.
        do_reset();
        @(negedge clk);
        req = 4'b0001; data = 32'h0000_0055;
        repeat (5) @(negedge clk);
        req = '0;
        chk("mid_busy_before", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_gnt", int'(gnt), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_done", int'(done), 0);
        chk("mid_detx", int'(det_x), 0);
        chk("mid_detrst", int'(det_rst), 0);
        chk("mid_hit", int'(hit_count), 0);
        @(negedge clk);
        rst = 1'b1;
        m_last = N - 1;
        run_job("post_rst", 4'b0001, 32'h0000_0055, 0, 4);

        // Random jobs, data scrambled after grant to confirm it is ignored.
        for (int it = 0; it < 60; it++) begin
            rv = N'($urandom_range(1, (1 << N) - 1));
            dv = $urandom;
            eid  = rr_pick(rv, m_last);
            ehit = exp_hits(dv[eid*W +: W]);
            @(negedge clk);
            req = rv; data = dv;
            @(negedge clk);
            chk("rnd_gnt", int'(gnt), 1 << eid);
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                data = $urandom;
            end
            wait_done("rnd", ok);
            if (ok) begin
                chk("rnd_id", int'(done_id), eid);
                chk("rnd_hit", int'(hit_count), ehit);
            end
            req = '0;
            m_last = eid;
        end

`ifdef ZD_SCHED_STATS_EN
        do_reset();
        chk("stats_rst", int'(total_hits), 0);
        run_job("stats55", 4'b0001, 32'h0000_0055, 0, 4);
        @(negedge clk);
        chk("stats_total1", int'(total_hits), 4);
        run_job("stats0f", 4'b0001, 32'h0000_000F, 0, 1);
        @(negedge clk);
        chk("stats_total2", int'(total_hits), 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/zd_sched.md
Name: zd_sched

Overview:
- Round-robin scheduler that shares one bit-serial Mealy zero detector among N requesters.
- Each granted requester's W-bit word goes to the detector LSB-first. The scheduler clears the detector before each word and counts cycles with det_y high.
- It returns the count to the requester with a one-cycle done pulse.
- Sits between parallel producers and the single external detector instance.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, word width in bits shifted per job (2..32)
- CW, $clog2(W+1), hit count width (derived, localparam)

Ports:
- clk  in  1  clock, all flops on rising edge
- rst  in  1  asynchronous active-low reset
- req  in  N  per-requester job request, level
- data  in  N*W  requester words; slice i = data[i*W +: W]
- gnt  out  N  one-hot grant, held from CLEAR through REPORT
- det_x  out  1  serial bit to detector x_in
- det_rst  out  1  registered active-low clear to detector rst
- det_y  in  1  detector y_out (Mealy, combinational on det_x)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse in REPORT
- done_id  out  $clog2(N)  index of finished requester, held until next done
- hit_count  out  CW  number of det_y=1 samples for finished job, held until next done

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, port rst.
- Reset values:
  - state=IDLE; gnt=0, det_rst=0 (detector held clear), det_x=0, busy=0, done=0, done_id=0, hit_count=0
  - round-robin pointer: last=N-1, so requester 0 has first priority
- FSM states: IDLE, CLEAR, SHIFT, REPORT.
- IDLE:
  - det_rst=1.
  - If any req bit is set, select the first set bit searching from (last+1) mod N upward with wrap.
  - On that edge: latch the word into the shift register, set gnt one-hot, set last=sel, clear the counter, go to CLEAR.
  - If no req is set, stay in IDLE.
- CLEAR (1 cycle): det_rst=0 and bit_cnt=0; go to SHIFT.
- SHIFT (exactly W cycles):
  - det_rst=1; det_x = shift register bit 0 (combinational from the register).
  - Each cycle, sample det_y at the clock edge; if it is 1, increment the counter.
  - Shift right by one and increment bit_cnt.
  - After the W-th cycle, go to REPORT.
- REPORT (1 cycle): done=1; done_id and hit_count load from the job registers; gnt drops on exit; go to IDLE.
- Latency:
  - req seen in IDLE at cycle t → gnt high at t+1 → done at t+W+2.
  - Next grant is no earlier than t+W+4, because IDLE lasts at least 1 cycle.
- Data is sampled only at the grant edge; req and data changes after that are ignored.
- A requester that keeps req high after its done is re-arbitrated. Round-robin ensures every other pending requester is served first.
- Simultaneous requests: exactly one grant. A requester losing arbitration keeps waiting; it is never dropped.
- Counter cannot overflow: the maximum is W, and CW holds W.
- Async reset mid-job aborts immediately: all outputs return to reset values, no done is issued, and the detector is held clear.
- det_x is 0 outside SHIFT.

Optional Feature:
- Macro: ZD_SCHED_STATS_EN.
- Defined:
  - Adds output total_hits [15:0], the cumulative sum of hit_count over all completed jobs.
  - Updated in REPORT; saturates at 16'hFFFF; cleared only by rst.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan (bench detector model: after clear, y=1 when det_x=0 and at least one earlier bit since clear was 1 and the previous bit was 1, else 0; N=4, W=8):
- req=4'b0001, data0=8'h55 → gnt=0001 one cycle later; det_rst low 1 cycle; det_x sequence 1,0,1,0,1,0,1,0; done at t+10 with done_id=0, hit_count=4.
- Sequential jobs, one at a time, on requester 1 → data1=8'h00 gives hit_count=0; data1=8'hFF gives 0; data1=8'h0F gives 1; each with done_id=1.
- req=4'b1111 held continuously → done_id sequence 0,1,2,3,0; each gnt one-hot and never overlapping.
- After requester 0 is served, req=4'b1001 → next grant goes to 3, then 0.
- rst asserted mid-SHIFT → gnt, busy, done and det_x go to 0 and det_rst to 0 immediately. After release, a fresh req=0001, data0=8'h55 completes with hit_count=4.
- With ZD_SCHED_STATS_EN: jobs 8'h55 then 8'h0F → total_hits=4 then 5.
